// File: rtl/schedule_1.sv
// First scheduling stage: each cycle it issues the lowest-index hazard-free pool slot and tracks pending writes in a scoreboard.
// Optional feature: define SCHED_WB_BYPASS_EN to let a same-cycle writeback unblock a waiting instruction.
module schedule_1 #(
    parameter int COP_NUMS = 32'd1,
    parameter int PNUMS    = COP_NUMS + 1,
    parameter int SW       = (PNUMS > 1) ? $clog2(PNUMS) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FLUSH,
    input  logic                  STALL,
    input  logic                  MMU_WAIT,
    input  logic [32*PNUMS-1:0]   POOL_PC,
    input  logic [17*PNUMS-1:0]   POOL_OPCODE,
    input  logic [5*PNUMS-1:0]    POOL_RD,
    input  logic [5*PNUMS-1:0]    POOL_RS1,
    input  logic [5*PNUMS-1:0]    POOL_RS2,
    input  logic [32*PNUMS-1:0]   POOL_RINST,
    input  logic                  WB_VALID,
    input  logic [4:0]            WB_RD,
    output logic                  HAZARD_STALL,
    output logic                  SCHED_VALID,
    output logic [SW-1:0]         SCHED_SEL,
    output logic [31:0]           SCHED_PC,
    output logic [16:0]           SCHED_OPCODE,
    output logic [4:0]            SCHED_RD,
    output logic [4:0]            SCHED_RS1,
    output logic [4:0]            SCHED_RS2,
    output logic [31:0]           SCHED_RINST
);

    localparam logic [16:0] NOP_OPCODE = 17'h04C00;
    localparam logic [31:0] NOP_RINST  = 32'h0000_0013;
    localparam logic [31:0] EMPTY_SLOT = 32'hFFFF_FFFF;

    logic [31:0]      busy_reg;
    logic [31:0]      busy_next;
    logic [31:0]      busy_chk;
    logic [31:0]      wb_mask;
    logic [31:0]      set_mask;
    logic             hold;

    logic [PNUMS-1:0] slot_valid;
    logic [PNUMS-1:0] slot_blocked;
    logic [31:0]      slot_pc     [PNUMS];
    logic [16:0]      slot_opcode [PNUMS];
    logic [4:0]       slot_rd     [PNUMS];
    logic [4:0]       slot_rs1    [PNUMS];
    logic [4:0]       slot_rs2    [PNUMS];
    logic [31:0]      slot_rinst  [PNUMS];

    logic             issue_found;
    logic             issue_en;
    logic [SW-1:0]    issue_sel;
    logic             pending;
    logic [31:0]      sel_pc;
    logic [16:0]      sel_opcode;
    logic [4:0]       sel_rd;
    logic [4:0]       sel_rs1;
    logic [4:0]       sel_rs2;
    logic [31:0]      sel_rinst;

    assign hold    = STALL | MMU_WAIT;
    assign wb_mask = WB_VALID ? (32'd1 << WB_RD) : 32'd0;

`ifdef SCHED_WB_BYPASS_EN
    assign busy_chk = busy_reg & ~wb_mask;
`else
    assign busy_chk = busy_reg;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < PNUMS; gi++) begin : g_slot
            assign slot_pc[gi]     = POOL_PC[32*gi +: 32];
            assign slot_opcode[gi] = POOL_OPCODE[17*gi +: 17];
            assign slot_rd[gi]     = POOL_RD[5*gi +: 5];
            assign slot_rs1[gi]    = POOL_RS1[5*gi +: 5];
            assign slot_rs2[gi]    = POOL_RS2[5*gi +: 5];
            assign slot_rinst[gi]  = POOL_RINST[32*gi +: 32];
            assign slot_valid[gi]  = (slot_rinst[gi] != EMPTY_SLOT);
            // x0 is excluded explicitly so a stray bit 0 can never block
            assign slot_blocked[gi] = ((slot_rs1[gi] != 5'd0) && busy_chk[slot_rs1[gi]]) ||
                                      ((slot_rs2[gi] != 5'd0) && busy_chk[slot_rs2[gi]]) ||
                                      ((slot_rd[gi]  != 5'd0) && busy_chk[slot_rd[gi]]);
        end
    endgenerate

    always_comb begin
        issue_found = 1'b0;
        issue_sel   = '0;
        for (int i = 0; i < PNUMS; i++) begin
            if (!issue_found && slot_valid[i] && !slot_blocked[i]) begin
                issue_found = 1'b1;
                issue_sel   = SW'(i);
            end
        end
    end

    assign issue_en = issue_found && !hold;

    always_comb begin
        sel_pc     = 32'd0;
        sel_opcode = NOP_OPCODE;
        sel_rd     = 5'd0;
        sel_rs1    = 5'd0;
        sel_rs2    = 5'd0;
        sel_rinst  = NOP_RINST;
        pending    = 1'b0;
        for (int i = 0; i < PNUMS; i++) begin
            if (issue_sel == SW'(i)) begin
                sel_pc     = slot_pc[i];
                sel_opcode = slot_opcode[i];
                sel_rd     = slot_rd[i];
                sel_rs1    = slot_rs1[i];
                sel_rs2    = slot_rs2[i];
                sel_rinst  = slot_rinst[i];
            end
            if (slot_valid[i] && !(issue_en && (issue_sel == SW'(i))))
                pending = 1'b1;
        end
    end

    assign HAZARD_STALL = hold | pending;

    // Set after clear so an issue to the register being written back keeps it busy
    assign set_mask  = (issue_en && (sel_rd != 5'd0)) ? (32'd1 << sel_rd) : 32'd0;
    assign busy_next = ((busy_reg & ~wb_mask) | set_mask) & ~32'd1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_reg     <= 32'd0;
            SCHED_VALID  <= 1'b0;
            SCHED_SEL    <= '0;
            SCHED_PC     <= 32'd0;
            SCHED_OPCODE <= NOP_OPCODE;
            SCHED_RD     <= 5'd0;
            SCHED_RS1    <= 5'd0;
            SCHED_RS2    <= 5'd0;
            SCHED_RINST  <= NOP_RINST;
        end else if (FLUSH) begin
            busy_reg     <= 32'd0;
            SCHED_VALID  <= 1'b0;
            SCHED_SEL    <= '0;
            SCHED_PC     <= 32'd0;
            SCHED_OPCODE <= NOP_OPCODE;
            SCHED_RD     <= 5'd0;
            SCHED_RS1    <= 5'd0;
            SCHED_RS2    <= 5'd0;
            SCHED_RINST  <= NOP_RINST;
        end else begin
            busy_reg <= busy_next;
            if (!hold) begin
                if (issue_en) begin
                    SCHED_VALID  <= 1'b1;
                    SCHED_SEL    <= issue_sel;
                    SCHED_PC     <= sel_pc;
                    SCHED_OPCODE <= sel_opcode;
                    SCHED_RD     <= sel_rd;
                    SCHED_RS1    <= sel_rs1;
                    SCHED_RS2    <= sel_rs2;
                    SCHED_RINST  <= sel_rinst;
                end else begin
                    SCHED_VALID  <= 1'b0;
                    SCHED_SEL    <= '0;
                    SCHED_PC     <= 32'd0;
                    SCHED_OPCODE <= NOP_OPCODE;
                    SCHED_RD     <= 5'd0;
                    SCHED_RS1    <= 5'd0;
                    SCHED_RS2    <= 5'd0;
                    SCHED_RINST  <= NOP_RINST;
                end
            end
        end
    end

endmodule

// File: tb/tb_schedule_1.sv
// Directed, table-driven bench for schedule_1 with two pool slots (main core + one coprocessor).
module tb_schedule_1;

    localparam int PNUMS = 2;
    localparam int SW    = 1;

    logic                CLK = 1'b0;
    logic                RST;
    logic                FLUSH, STALL, MMU_WAIT;
    logic [32*PNUMS-1:0] POOL_PC;
    logic [17*PNUMS-1:0] POOL_OPCODE;
    logic [5*PNUMS-1:0]  POOL_RD, POOL_RS1, POOL_RS2;
    logic [32*PNUMS-1:0] POOL_RINST;
    logic                WB_VALID;
    logic [4:0]          WB_RD;
    logic                HAZARD_STALL, SCHED_VALID;
    logic [SW-1:0]       SCHED_SEL;
    logic [31:0]         SCHED_PC, SCHED_RINST;
    logic [16:0]         SCHED_OPCODE;
    logic [4:0]          SCHED_RD, SCHED_RS1, SCHED_RS2;

    int total = 0;
    int bad   = 0;

    schedule_1 dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .STALL(STALL), .MMU_WAIT(MMU_WAIT),
        .POOL_PC(POOL_PC), .POOL_OPCODE(POOL_OPCODE), .POOL_RD(POOL_RD),
        .POOL_RS1(POOL_RS1), .POOL_RS2(POOL_RS2), .POOL_RINST(POOL_RINST),
        .WB_VALID(WB_VALID), .WB_RD(WB_RD), .HAZARD_STALL(HAZARD_STALL),
        .SCHED_VALID(SCHED_VALID), .SCHED_SEL(SCHED_SEL), .SCHED_PC(SCHED_PC),
        .SCHED_OPCODE(SCHED_OPCODE), .SCHED_RD(SCHED_RD), .SCHED_RS1(SCHED_RS1),
        .SCHED_RS2(SCHED_RS2), .SCHED_RINST(SCHED_RINST)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int flush, stall, mmu, wbv, wbrd;
        int v0, pc0, rd0, s10, s20;
        int v1, pc1, rd1, s11, s21;
        int ehz, ev, esel, epc, erd, ers1, ers2;
    } vec_t;

    vec_t vq[$];

    function automatic logic [16:0] opc_of(input logic [31:0] pc);
        return pc[16:0] ^ 17'h1ABCD;
    endfunction

    function automatic logic [31:0] rinst_of(input logic [31:0] pc);
        return {pc[15:0], 16'h0033};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive_pool(input int v0, input int pc0, input int rd0, input int s10, input int s20,
                              input int v1, input int pc1, input int rd1, input int s11, input int s21);
        logic [31:0] p0, p1;
        p0 = 32'(pc0);
        p1 = 32'(pc1);
        POOL_PC     = {p1, p0};
        POOL_OPCODE = {opc_of(p1), opc_of(p0)};
        POOL_RD     = {5'(rd1), 5'(rd0)};
        POOL_RS1    = {5'(s11), 5'(s10)};
        POOL_RS2    = {5'(s21), 5'(s20)};
        POOL_RINST  = {(v1 != 0) ? rinst_of(p1) : 32'hFFFF_FFFF,
                       (v0 != 0) ? rinst_of(p0) : 32'hFFFF_FFFF};
    endtask

    task automatic check_outputs(input int idx, input int ev, input int esel, input int epc,
                                 input int erd, input int ers1, input int ers2);
        logic [31:0] pc;
        pc = 32'(epc);
        chk("valid", idx, 32'(SCHED_VALID), 32'(ev));
        chk("sel",   idx, 32'(SCHED_SEL),   32'(esel));
        chk("pc",    idx, SCHED_PC,         pc);
        chk("opcode", idx, 32'(SCHED_OPCODE), (ev != 0) ? 32'(opc_of(pc)) : 32'h04C00);
        chk("rd",    idx, 32'(SCHED_RD),    32'(erd));
        chk("rs1",   idx, 32'(SCHED_RS1),   32'(ers1));
        chk("rs2",   idx, 32'(SCHED_RS2),   32'(ers2));
        chk("rinst", idx, SCHED_RINST,      (ev != 0) ? rinst_of(pc) : 32'h0000_0013);
    endtask

    initial begin
        // RAW on x5
        vq.push_back(vec_t'{0,0,0,0,0, 0,0,0,0,0,          0,0,0,0,0, 0,0,0,0,0,0,0});
        vq.push_back(vec_t'{0,0,0,0,0, 1,'h100,5,0,0,      0,0,0,0,0, 0,1,0,'h100,5,0,0});
        vq.push_back(vec_t'{0,0,0,0,0, 1,'h104,6,5,1,      0,0,0,0,0, 1,0,0,0,0,0,0});
`ifdef SCHED_WB_BYPASS_EN
        vq.push_back(vec_t'{0,0,0,1,5, 1,'h104,6,5,1,      0,0,0,0,0, 0,1,0,'h104,6,5,1});
        vq.push_back(vec_t'{0,0,0,0,0, 0,0,0,0,0,          0,0,0,0,0, 0,0,0,0,0,0,0});
`else
        vq.push_back(vec_t'{0,0,0,1,5, 1,'h104,6,5,1,      0,0,0,0,0, 1,0,0,0,0,0,0});
        vq.push_back(vec_t'{0,0,0,0,0, 1,'h104,6,5,1,      0,0,0,0,0, 0,1,0,'h104,6,5,1});
`endif
        vq.push_back(vec_t'{0,0,0,1,6, 0,0,0,0,0,          0,0,0,0,0, 0,0,0,0,0,0,0});
        // slot priority and WAW
        vq.push_back(vec_t'{0,0,0,0,0, 1,'h200,7,0,0,      0,0,0,0,0, 0,1,0,'h200,7,0,0});
        vq.push_back(vec_t'{0,0,0,0,0, 1,'h204,8,7,0,      1,'h300,10,1,2, 1,1,1,'h300,10,1,2});
        vq.push_back(vec_t'{0,0,0,0,0, 1,'h208,10,0,0,     0,0,0,0,0, 1,0,0,0,0,0,0});
        vq.push_back(vec_t'{0,0,0,1,7, 0,0,0,0,0,          0,0,0,0,0, 0,0,0,0,0,0,0});
        vq.push_back(vec_t'{0,0,0,1,10, 0,0,0,0,0,         0,0,0,0,0, 0,0,0,0,0,0,0});
        // stall hold, writeback clear during stall
        vq.push_back(vec_t'{0,0,0,0,0, 1,'h400,9,0,0,      0,0,0,0,0, 0,1,0,'h400,9,0,0});
        vq.push_back(vec_t'{0,1,0,0,0, 1,'h404,11,0,0,     1,'h500,12,0,0, 1,1,0,'h400,9,0,0});
        vq.push_back(vec_t'{0,1,0,1,9, 1,'h404,11,0,0,     1,'h500,12,0,0, 1,1,0,'h400,9,0,0});
        vq.push_back(vec_t'{0,1,0,0,0, 1,'h404,11,0,0,     1,'h500,12,0,0, 1,1,0,'h400,9,0,0});
        vq.push_back(vec_t'{0,0,0,0,0, 1,'h408,13,9,0,     1,'h504,11,0,0, 1,1,0,'h408,13,9,0});
        vq.push_back(vec_t'{0,0,0,0,0, 1,'h40C,14,11,12,   0,0,0,0,0, 0,1,0,'h40C,14,11,12});
        // flush with stall high
        vq.push_back(vec_t'{0,0,0,0,0, 1,'h600,3,0,0,      0,0,0,0,0, 0,1,0,'h600,3,0,0});
        vq.push_back(vec_t'{1,1,0,0,0, 1,'h604,15,3,0,     0,0,0,0,0, 1,0,0,0,0,0,0});
        vq.push_back(vec_t'{0,0,0,0,0, 1,'h608,16,3,13,    1,'h700,17,14,0, 1,1,0,'h608,16,3,13});
        vq.push_back(vec_t'{0,0,0,0,0, 0,0,0,0,0,          1,'h700,17,14,0, 0,1,1,'h700,17,14,0});
        // x0 destination, set beats clear
        vq.push_back(vec_t'{0,0,0,0,0, 1,'h800,0,0,0,      0,0,0,0,0, 0,1,0,'h800,0,0,0});
        vq.push_back(vec_t'{0,0,0,1,4, 1,'h804,4,0,0,      0,0,0,0,0, 0,1,0,'h804,4,0,0});
        vq.push_back(vec_t'{0,0,0,0,0, 1,'h808,19,4,0,     0,0,0,0,0, 1,0,0,0,0,0,0});
        vq.push_back(vec_t'{0,0,0,1,4, 0,0,0,0,0,          0,0,0,0,0, 0,0,0,0,0,0,0});
        vq.push_back(vec_t'{0,0,0,0,0, 1,'h808,19,4,0,     0,0,0,0,0, 0,1,0,'h808,19,4,0});
        // MMU_WAIT behaves as STALL
        vq.push_back(vec_t'{0,0,1,0,0, 1,'h900,20,0,0,     0,0,0,0,0, 1,1,0,'h808,19,4,0});
        vq.push_back(vec_t'{0,0,0,0,0, 1,'h900,20,0,0,     0,0,0,0,0, 0,1,0,'h900,20,0,0});
        // flush without stall must not set busy
        vq.push_back(vec_t'{1,0,0,0,0, 1,'hA00,21,0,0,     0,0,0,0,0, 0,0,0,0,0,0,0});
        vq.push_back(vec_t'{0,0,0,0,0, 1,'hA04,22,21,0,    0,0,0,0,0, 0,1,0,'hA04,22,21,0});

        RST = 1'b1; FLUSH = 1'b0; STALL = 1'b0; MMU_WAIT = 1'b0;
        WB_VALID = 1'b0; WB_RD = 5'd0;
        drive_pool(0,0,0,0,0, 0,0,0,0,0);
        #1;
        chk("rst_hazard", -1, 32'(HAZARD_STALL), 32'd0);
        check_outputs(-1, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            v = vq[i];
            @(negedge CLK);
            FLUSH    = (v.flush != 0);
            STALL    = (v.stall != 0);
            MMU_WAIT = (v.mmu != 0);
            WB_VALID = (v.wbv != 0);
            WB_RD    = 5'(v.wbrd);
            drive_pool(v.v0, v.pc0, v.rd0, v.s10, v.s20, v.v1, v.pc1, v.rd1, v.s11, v.s21);
            #1;
            chk("hazard", i, 32'(HAZARD_STALL), 32'(v.ehz));
            @(posedge CLK);
            #1;
            check_outputs(i, v.ev, v.esel, v.epc, v.erd, v.ers1, v.ers2);
            $display("vec %0d: hz=%0b valid=%0b sel=%0d pc=%h rd=%0d", i, HAZARD_STALL,
                     SCHED_VALID, SCHED_SEL, SCHED_PC, SCHED_RD);
        end

        // Asynchronous reset in the middle of a cycle
        @(negedge CLK);
        FLUSH = 1'b0; STALL = 1'b0; MMU_WAIT = 1'b0; WB_VALID = 1'b0; WB_RD = 5'd0;
        drive_pool(1,'hB00,23,0,0, 0,0,0,0,0);
        @(posedge CLK);
        #1;
        check_outputs(100, 1, 0, 'hB00, 23, 0, 0);
        #2;
        RST = 1'b1;
        #1;
        check_outputs(101, 0, 0, 0, 0, 0, 0);
        $display("async reset: valid=%0b opcode=%h rinst=%h", SCHED_VALID, SCHED_OPCODE, SCHED_RINST);
        @(negedge CLK);
        RST = 1'b0;
        drive_pool(1,'hB04,24,23,22, 0,0,0,0,0);
        #1;
        chk("post_rst_hazard", 102, 32'(HAZARD_STALL), 32'd0);
        @(posedge CLK);
        #1;
        check_outputs(102, 1, 0, 'hB04, 24, 23, 22);
        $display("post reset issue: valid=%0b pc=%h", SCHED_VALID, SCHED_PC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
